// File: rtl/dcache_axi_wbridge_pkg.sv
// Shared constants and FSM encoding for the dirty-line AXI write bridge.
package dcache_axi_wbridge_pkg;

    localparam int WAY_BUS_W = 256;
    localparam int LINE_W    = WAY_BUS_W;
    localparam int WORD_W    = 32;
    localparam int BEATS     = LINE_W / WORD_W;
    localparam int CNT_W     = $clog2(BEATS);

    localparam logic [3:0] AXI_ID_DEFAULT = 4'h1;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wb_state_e;

endpackage

// File: rtl/dcache_axi_wbridge_line_serializer.sv
// Holds one captured cache line and steps through its 32-bit words, low word first.
module dcache_axi_wbridge_line_serializer
    import dcache_axi_wbridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LINE_W-1:0] line_i,
    input  logic              advance,
    output logic [WORD_W-1:0] word,
    output logic              last
);

    logic [BEATS-1:0][WORD_W-1:0] line_q;
    logic [CNT_W-1:0]             cnt_q;

    // The counter parks on the final word until the next line is loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            line_q <= line_i;
            cnt_q  <= '0;
        end else if (advance && !last) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign word = line_q[cnt_q];
    assign last = (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/dcache_axi_wbridge.sv
// Issues one 256-bit dirty line as an 8-beat x 32-bit AXI INCR write burst.
// WBRIDGE_AW_W_OVERLAP_EN: drive AW and W concurrently instead of strictly in sequence.
//
//   state | meaning
//   IDLE  | waiting for wen_i; line and address captured on accept
//   AW    | address phase (with overlap: address and data phases together)
//   W     | data beats, sequential build only
//   B     | waiting for write response
module dcache_axi_wbridge
    import dcache_axi_wbridge_pkg::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_i,
    input  logic [31:0]       awaddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic              bvalid_o,
    output logic              busy_o,
    output logic [3:0]        awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [WORD_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    wb_state_e   state_q, state_d;
    logic        accept, aw_hs, w_hs, w_last_hs, b_hs;
    logic        cur_last;
    logic [31:0] awaddr_q;
    logic        unused_ok;

    assign accept    = (state_q == ST_IDLE) && wen_i;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign w_last_hs = w_hs && cur_last;
    assign b_hs      = bvalid && bready;

    // Response code has no consumer: a non-OKAY burst still retires the entry.
    assign unused_ok = ^{bid, bresp ^ AXI_RESP_OKAY, awaddr_i[4:0]};

    dcache_axi_wbridge_line_serializer u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .line_i  (wdata_i),
        .advance (w_hs),
        .word    (wdata),
        .last    (cur_last)
    );

`ifdef WBRIDGE_AW_W_OVERLAP_EN
    logic aw_done_q, w_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs)     aw_done_q <= 1'b1;
            if (w_last_hs) w_done_q  <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (wen_i) state_d = ST_AW;
`ifdef WBRIDGE_AW_W_OVERLAP_EN
            ST_AW:   if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) state_d = ST_B;
`else
            ST_AW:   if (aw_hs) state_d = ST_W;
`endif
            ST_W:    if (w_last_hs) state_d = ST_B;
            ST_B:    if (b_hs) state_d = ST_IDLE;
        endcase
    end

    // Valids decode the state register only, so no ready feeds a valid.
    always_comb begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (state_q)
            ST_IDLE: ;
`ifdef WBRIDGE_AW_W_OVERLAP_EN
            ST_AW: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
`else
            ST_AW:   awvalid = 1'b1;
`endif
            ST_W:    wvalid = 1'b1;
            ST_B:    bready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            awaddr_q <= '0;
            bvalid_o <= 1'b0;
        end else begin
            if (accept) awaddr_q <= {awaddr_i[31:5], 5'b0};
            bvalid_o <= b_hs;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign awid    = AXI_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign wid     = AXI_ID;
    assign wstrb   = 4'hF;
    assign wlast   = wvalid && cur_last;

endmodule

// File: tb/tb_dcache_axi_wbridge.sv
// Scoreboard bench for dcache_axi_wbridge: stimulus queues expected AW/W/B traffic, a monitor checks it.
module tb_dcache_axi_wbridge;

`ifdef WBRIDGE_AW_W_OVERLAP_EN
    localparam int EXP_LAT = 10;
`else
    localparam int EXP_LAT = 11;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wen_i = 1'b0;
    logic [31:0]  awaddr_i = '0;
    logic [255:0] wdata_i = '0;
    logic         bvalid_o, busy_o;
    logic [3:0]   awid, wid;
    logic [31:0]  awaddr, wdata;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [3:0]   wstrb;
    logic         awvalid, wvalid, wlast, bready;
    logic         awready = 1'b1;
    logic         wready = 1'b1;
    logic         bvalid = 1'b0;
    logic [3:0]   bid = 4'h1;
    logic [1:0]   bresp = 2'b00;

    always #5 clk = ~clk;

    dcache_axi_wbridge dut (
        .clk(clk), .rst(rst), .wen_i(wen_i), .awaddr_i(awaddr_i), .wdata_i(wdata_i),
        .bvalid_o(bvalid_o), .busy_o(busy_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard
    logic [31:0] exp_aw_q[$];
    logic [32:0] exp_w_q[$];
    int          exp_b_t0[$];
    int          exp_b_lat[$];
    int          n_req = 0;
    int          n_abort = 0;
    int          aw_seen = 0;
    int          b_seen = 0;
    bit          mon_en = 1'b0;
    bit          txn_aw_done = 1'b0;

    // ready / response drivers
    int aw_delay = 0;
    int b_delay = 0;
    bit w_toggle_en = 1'b0;
    bit w_tog = 1'b1;
    int aw_cnt = 0;
    int b_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!awvalid) aw_cnt = 0;
        awready = awvalid ? (aw_cnt >= aw_delay) : (aw_delay == 0);
        if (awvalid) aw_cnt++;
        wready = w_toggle_en ? w_tog : 1'b1;
        w_tog = ~w_tog;
        if (!bready) b_cnt = 0;
        bvalid = bready && (b_cnt >= b_delay);
        if (bready) b_cnt++;
    end

    // monitor
    logic        p_awvalid = 0, p_awready = 0, p_wvalid = 0, p_wready = 0;
    logic        p_bready = 0, p_bvalid = 0, p_wlast = 0, p_bvalid_o = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0;

    always @(negedge clk) begin
        logic [32:0] ew;
        int t0, lat;
        if (rst && mon_en) begin
            if (p_awvalid && !p_awready) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, p_awaddr);
            end
            if (p_wvalid && !p_wready) begin
                chk("w_hold_valid", wvalid, 1);
                chk("w_hold_data", wdata, p_wdata);
                chk("w_hold_last", wlast, p_wlast);
            end
            if (p_bready && !p_bvalid) chk("b_hold_ready", bready, 1);
            if (p_bvalid_o) chk("bvalid_o_one_cycle", bvalid_o, 0);
            if (awvalid && awready) begin
                aw_seen++;
                txn_aw_done = 1'b1;
                if (exp_aw_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL aw_unexpected: got awaddr 0x%0h, required no AW", awaddr);
                end else begin
                    chk("awaddr", awaddr, exp_aw_q.pop_front());
                    chk("awlen", awlen, 8'd7);
                    chk("awsize", awsize, 3'b010);
                    chk("awburst", awburst, 2'b01);
                    chk("awid", awid, 4'h1);
                end
            end
            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL w_unexpected: got wdata 0x%0h, required no beat", wdata);
                end else begin
                    ew = exp_w_q.pop_front();
                    chk("wdata", wdata, ew[31:0]);
                    chk("wlast", wlast, ew[32]);
                    chk("wstrb_wid", {wstrb, wid}, 8'hF1);
                end
            end
            if (bready && !p_bready) chk("bready_after_aw", txn_aw_done, 1);
            if (bvalid_o) begin
                b_seen++;
                txn_aw_done = 1'b0;
                if (exp_b_t0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected: got bvalid_o 1, required 0");
                end else begin
                    t0  = exp_b_t0.pop_front();
                    lat = exp_b_lat.pop_front();
                    if (lat >= 0) chk("latency", cyc - t0, lat);
                    chk("beats_left_at_b", exp_w_q.size(), 0);
                end
            end
        end
        p_awvalid = awvalid; p_awready = awready; p_awaddr = awaddr;
        p_wvalid = wvalid; p_wready = wready; p_wdata = wdata; p_wlast = wlast;
        p_bready = bready; p_bvalid = bvalid; p_bvalid_o = bvalid_o;
    end

    // stimulus helpers; called at #1 after a rising edge
    task automatic start_req(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [255:0] data, input int lat);
        exp_aw_q.push_back(exp_addr);
        for (int k = 0; k < 8; k++) exp_w_q.push_back({(k == 7), data[32*k +: 32]});
        exp_b_t0.push_back(cyc);
        exp_b_lat.push_back(lat);
        n_req++;
        wen_i = 1'b1;
        awaddr_i = addr;
        wdata_i = data;
    endtask

    task automatic wait_done(input int limit);
        bit done = 1'b0;
        for (int n = 0; n < limit && !done; n++) begin
            @(negedge clk);
            if (bvalid_o) done = 1'b1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL completion_timeout: got no bvalid_o in %0d cycles, required one", limit);
        end
        wen_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_awvalid"}, awvalid, 0);
        chk({tag, "_wvalid"}, wvalid, 0);
        chk({tag, "_wlast"}, wlast, 0);
        chk({tag, "_bready"}, bready, 0);
        chk({tag, "_bvalid_o"}, bvalid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_awaddr"}, awaddr, 0);
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // single write, readies high
        start_req(32'h8000_1234, 32'h8000_1220, mk_line(32'h1111_0000), EXP_LAT);
        wait_done(60);
        repeat (2) @(posedge clk); #1;

        // backpressure on every channel, SLVERR response still completes
        aw_delay = 3; b_delay = 5; w_toggle_en = 1'b1; bresp = 2'b10;
        start_req(32'h1234_567F, 32'h1234_5660, mk_line(32'hC0DE_0010), -1);
        wait_done(120);
        aw_delay = 0; b_delay = 0; w_toggle_en = 1'b0; bresp = 2'b00;
        repeat (2) @(posedge clk); #1;

        // source data changes after accept
        start_req(32'h0000_1000, 32'h0000_1000, mk_line(32'h5555_0000), EXP_LAT);
        @(posedge clk); #1;
        wdata_i = '1;
        wait_done(60);
        repeat (2) @(posedge clk); #1;

        // back-to-back entries
        start_req(32'h0000_0040, 32'h0000_0040, mk_line(32'h4040_0000), EXP_LAT);
        wait_done(60);
        start_req(32'h0000_0060, 32'h0000_0060, mk_line(32'h6060_0000), EXP_LAT);
        wait_done(60);
        repeat (2) @(posedge clk); #1;

        // async reset while beat 3 is on the bus
        start_req(32'h2000_0100, 32'h2000_0100, mk_line(32'h7777_0000), -1);
        repeat (EXP_LAT - 6) @(posedge clk);
        #2;
        chk("pre_reset_busy", busy_o, 1);
        chk("pre_reset_beat3", wdata, 32'h7777_0003);
        mon_en = 1'b0;
        rst = 1'b0;
        wen_i = 1'b0;
        n_abort++;
        #1;
        check_idle_outputs("midw_reset");
        exp_aw_q.delete(); exp_w_q.delete(); exp_b_t0.delete(); exp_b_lat.delete();
        txn_aw_done = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        start_req(32'h2000_0120, 32'h2000_0120, mk_line(32'h9999_0000), EXP_LAT);
        wait_done(60);
        repeat (2) @(posedge clk); #1;

`ifdef WBRIDGE_AW_W_OVERLAP_EN
        // address accepted only after all data beats
        aw_delay = 12;
        start_req(32'h3000_0000, 32'h3000_0000, mk_line(32'hABCD_0000), -1);
        wait_done(80);
        aw_delay = 0;
        repeat (2) @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk); #1;
        chk("aw_total", aw_seen, n_req);
        chk("b_total", b_seen, n_req - n_abort);
        chk("aw_queue_empty", exp_aw_q.size(), 0);
        chk("w_queue_empty", exp_w_q.size(), 0);
        chk("final_idle", busy_o, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dcache_axi_wbridge.md
Name: dcache_axi_wbridge

Overview:
- Downstream neighbour of the data-cache write buffer.
- Takes one 256-bit dirty-line write request (level-held enable, line address, line data) and issues it as a single 8-beat x 32-bit AXI INCR write burst.
- Returns a one-cycle completion pulse on the B handshake, which the write buffer uses to retire its head entry.

Parameters:
- AXI_ID, 4'h1, constant value driven on awid/wid.
- BEATS, 8, beats per line; must equal line width / 32.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- wen_i  in  1  write request from write buffer; held until bvalid_o
- awaddr_i  in  32  line address; bits [4:0] ignored
- wdata_i  in  256  line data, word k = bits [32k+31:32k]
- bvalid_o  out  1  one-cycle pulse: line write completed
- busy_o  out  1  bridge not in IDLE
- awid  out  4  = AXI_ID
- awaddr  out  32  {awaddr_i[31:5],5'b0}, latched
- awlen  out  8  BEATS-1 (8'd7)
- awsize  out  3  3'b010
- awburst  out  2  2'b01 (INCR)
- awvalid  out  1  address valid
- awready  in  1  address ready
- wid  out  4  = AXI_ID
- wdata  out  32  current beat
- wstrb  out  4  4'hF
- wlast  out  1  final beat
- wvalid  out  1  data valid
- wready  in  1  data ready
- bid  in  4  ignored
- bresp  in  2  response code
- bvalid  in  1  response valid
- bready  out  1  response ready

Behaviour:
- Reset (rst low, async): state IDLE; awvalid, wvalid, wlast, bready, bvalid_o, busy_o = 0; beat counter = 0; latched address/data = 0. Reset mid-burst abandons the transaction; this is acceptable because the interconnect is reset by the same signal.
- States: IDLE -> AW -> W -> B -> IDLE.
- IDLE: if wen_i = 1, latch awaddr (aligned) and all 256 data bits, counter = 0, go to AW, assert awvalid next cycle. wen_i is sampled only in IDLE; later changes to wdata_i are ignored. A write-collision rewrite of the same address arrives as a fresh request after completion.
- AW: hold awvalid until awvalid & awready, then deassert awvalid and go to W with wvalid = 1.
- W:
  - wdata = latched word[counter]; wlast = (counter == BEATS-1).
  - On wvalid & wready: counter + 1. On the last beat, wvalid = 0 and go to B with bready = 1.
  - The counter is 3 bits and never wraps within a burst.
- B: on bvalid & bready, set bready = 0, pulse bvalid_o for exactly one cycle (registered), and return to IDLE.
  - bresp is not retried; a non-OKAY response still completes the transaction.
- Latency: with ready signals tied high, wen_i rises at cycle 0 → awvalid at 1 → beats at 2..9 → bready at 10 → bvalid at 10 → bvalid_o at 11. Minimum 11 cycles.
- Back-to-back requests: bvalid_o high drops wen_i in the same cycle (combinational in the buffer). In the cycle after bvalid_o, wen_i may be high with the next entry; IDLE accepts it with no bubble beyond that cycle.
- busy_o = (state != IDLE).
- All AXI outputs are registered; no combinational path from any AXI ready to an AXI valid.

Optional Feature:
- Macro: WBRIDGE_AW_W_OVERLAP_EN.
- Defined:
  - IDLE goes to AW with both awvalid and wvalid asserted; W beats may complete before, with, or after the AW handshake.
  - B is entered only after both the AW handshake and the last-beat handshake have completed; per-channel done flags are kept.
  - Minimum latency is 10 cycles.
- Undefined: strictly sequential behaviour as above.

Decomposition:
- Shared package/defines header holds:
  - state encodings (2 bits)
  - AXI_BURST_INCR
  - AXI_SIZE_4B
  - AXI_RESP_OKAY
  - line width 256, word width 32, beat count 8 (reusing the cache WayBus width constant)
- One sub-module is natural: line_serializer. It holds the 256-bit line register and 3-bit beat counter, and outputs the current word and a last flag.

Test Plan:
- Single write, all readies = 1: wen_i = 1, awaddr_i = 32'h8000_1234, wdata_i word k = 32'h1111_0000+k → awaddr = 32'h8000_1220, awlen = 7, 8 beats 0x11110000..0x11110007, wlast only on the 8th beat, a single bvalid_o pulse 11 cycles after the request.
- Backpressure: awready low for 3 cycles, wready toggling 1010..., bvalid delayed 5 cycles → awvalid/wvalid/bready hold stable, beat data is unchanged while stalled, exactly 8 W handshakes, one bvalid_o.
- Data change after accept: change wdata_i to all-ones one cycle after accept → beats still carry the original latched data.
- Back-to-back: two requests with addresses 32'h0000_0040 and 32'h0000_0060, wen_i held high across them → two bursts in order, two bvalid_o pulses, no extra AW issued.
- Async reset mid-W: deassert rst at beat 3 → all valids drop immediately, busy_o = 0; the next request starts a clean burst at beat 0.
- With WBRIDGE_AW_W_OVERLAP_EN and awready delayed until after wlast → bready is not asserted until the AW handshake completes; latency is 10 cycles when all readies = 1.
